// File: rtl/tl_to_axi4.sv
// TileLink-UL manager port to AXI4 master bridge.
//
// Accepts single-beat Get / PutFullData / PutPartialData on TL channel A. Each
// one becomes a single-beat AXI4 read (AR/R) or write (AW/W/B), and the bridge
// answers with AccessAckData / AccessAck on TL channel D. Only one transaction
// is in flight at a time. Opcodes other than Get/Put, and sizes above
// MAX_SIZE, are answered locally with denied=1 and cause no AXI traffic.
//
// Ports:
//   clock, reset       single clock, synchronous active-high reset
//   auto_in_a_*        TL channel A (request) from the manager
//   auto_in_d_*        TL channel D (response) to the manager
//   auto_out_aw/w/b_*  AXI4 write address / data / response channels
//   auto_out_ar/r_*    AXI4 read address / data channels
module tl_to_axi4 #(
  parameter int unsigned AXI_ID   = 0,
  parameter int unsigned MAX_SIZE = 5
) (
  input  logic         clock,
  input  logic         reset,
  output logic         auto_in_a_ready,
  input  logic         auto_in_a_valid,
  input  logic [2:0]   auto_in_a_bits_opcode,
  input  logic [2:0]   auto_in_a_bits_size,
  input  logic [8:0]   auto_in_a_bits_source,
  input  logic [35:0]  auto_in_a_bits_address,
  input  logic [31:0]  auto_in_a_bits_mask,
  input  logic [255:0] auto_in_a_bits_data,
  input  logic         auto_in_d_ready,
  output logic         auto_in_d_valid,
  output logic [2:0]   auto_in_d_bits_opcode,
  output logic [2:0]   auto_in_d_bits_size,
  output logic [8:0]   auto_in_d_bits_source,
  output logic         auto_in_d_bits_denied,
  output logic [255:0] auto_in_d_bits_data,
  output logic         auto_in_d_bits_corrupt,
  input  logic         auto_out_aw_ready,
  output logic         auto_out_aw_valid,
  output logic [3:0]   auto_out_aw_bits_id,
  output logic [35:0]  auto_out_aw_bits_addr,
  output logic [7:0]   auto_out_aw_bits_len,
  output logic [2:0]   auto_out_aw_bits_size,
  input  logic         auto_out_w_ready,
  output logic         auto_out_w_valid,
  output logic [255:0] auto_out_w_bits_data,
  output logic [31:0]  auto_out_w_bits_strb,
  output logic         auto_out_w_bits_last,
  output logic         auto_out_b_ready,
  input  logic         auto_out_b_valid,
  input  logic [3:0]   auto_out_b_bits_id,
  input  logic [1:0]   auto_out_b_bits_resp,
  input  logic         auto_out_ar_ready,
  output logic         auto_out_ar_valid,
  output logic [3:0]   auto_out_ar_bits_id,
  output logic [35:0]  auto_out_ar_bits_addr,
  output logic [7:0]   auto_out_ar_bits_len,
  output logic [2:0]   auto_out_ar_bits_size,
  output logic         auto_out_r_ready,
  input  logic         auto_out_r_valid,
  input  logic [3:0]   auto_out_r_bits_id,
  input  logic [255:0] auto_out_r_bits_data,
  input  logic [1:0]   auto_out_r_bits_resp,
  input  logic         auto_out_r_bits_last
);

  localparam logic [2:0] OpPutFull    = 3'd0;
  localparam logic [2:0] OpPutPartial = 3'd1;
  localparam logic [2:0] OpGet        = 3'd4;

  typedef enum logic [2:0] {
    StIdle,
    StAr,
    StR,
    StWr,
    StB,
    StResp
  } state_e;

  state_e state_q, state_d;

  logic [2:0]   size_q, size_d;
  logic [8:0]   source_q, source_d;
  logic [35:0]  addr_q, addr_d;
  logic [31:0]  mask_q, mask_d;
  logic [255:0] wdata_q, wdata_d;
  logic [2:0]   d_opcode_q, d_opcode_d;
  logic         d_denied_q, d_denied_d;
  logic         d_corrupt_q, d_corrupt_d;
  logic [255:0] d_data_q, d_data_d;
  logic         aw_done_q, aw_done_d;
  logic         w_done_q, w_done_d;

  logic a_is_get, a_is_put, a_size_ok;

  // IDs are fixed and len is 0, so returned ids and r_last carry no information.
  logic unused_inputs;
  assign unused_inputs = ^{auto_out_b_bits_id, auto_out_r_bits_id, auto_out_r_bits_last};

  assign a_is_get  = (auto_in_a_bits_opcode == OpGet);
  assign a_is_put  = (auto_in_a_bits_opcode == OpPutFull) ||
                     (auto_in_a_bits_opcode == OpPutPartial);
  assign a_size_ok = ({29'd0, auto_in_a_bits_size} <= MAX_SIZE);

  always_comb begin
    state_d     = state_q;
    size_d      = size_q;
    source_d    = source_q;
    addr_d      = addr_q;
    mask_d      = mask_q;
    wdata_d     = wdata_q;
    d_opcode_d  = d_opcode_q;
    d_denied_d  = d_denied_q;
    d_corrupt_d = d_corrupt_q;
    d_data_d    = d_data_q;
    aw_done_d   = aw_done_q;
    w_done_d    = w_done_q;

    unique case (state_q)
      StIdle: begin
        if (auto_in_a_valid) begin
          size_d      = auto_in_a_bits_size;
          source_d    = auto_in_a_bits_source;
          addr_d      = auto_in_a_bits_address;
          mask_d      = auto_in_a_bits_mask;
          wdata_d     = auto_in_a_bits_data;
          d_data_d    = '0;
          aw_done_d   = 1'b0;
          w_done_d    = 1'b0;
          d_opcode_d  = a_is_get ? 3'd1 : 3'd0;
          d_denied_d  = 1'b0;
          d_corrupt_d = 1'b0;
          if (a_size_ok && a_is_get) begin
            state_d = StAr;
          end else if (a_size_ok && a_is_put) begin
            state_d = StWr;
          end else begin
            // Answered locally; a denied Get also flags its (empty) data corrupt.
            d_denied_d  = 1'b1;
            d_corrupt_d = a_is_get;
            state_d     = StResp;
          end
        end
      end
      StAr: begin
        if (auto_out_ar_ready) state_d = StR;
      end
      StR: begin
        if (auto_out_r_valid) begin
          d_data_d    = auto_out_r_bits_data;
          d_denied_d  = (auto_out_r_bits_resp != 2'b00);
          d_corrupt_d = (auto_out_r_bits_resp != 2'b00);
          d_opcode_d  = 3'd1;
          state_d     = StResp;
        end
      end
      StWr: begin
        // AW and W complete independently; leave once both have handshaken.
        aw_done_d = aw_done_q | auto_out_aw_ready;
        w_done_d  = w_done_q | auto_out_w_ready;
        if (aw_done_d && w_done_d) state_d = StB;
      end
      StB: begin
        if (auto_out_b_valid) begin
          d_data_d    = '0;
          d_denied_d  = (auto_out_b_bits_resp != 2'b00);
          d_corrupt_d = 1'b0;
          d_opcode_d  = 3'd0;
          state_d     = StResp;
        end
      end
      StResp: begin
        if (auto_in_d_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= StIdle;
      size_q      <= '0;
      source_q    <= '0;
      addr_q      <= '0;
      mask_q      <= '0;
      wdata_q     <= '0;
      d_opcode_q  <= '0;
      d_denied_q  <= 1'b0;
      d_corrupt_q <= 1'b0;
      d_data_q    <= '0;
      aw_done_q   <= 1'b0;
      w_done_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      size_q      <= size_d;
      source_q    <= source_d;
      addr_q      <= addr_d;
      mask_q      <= mask_d;
      wdata_q     <= wdata_d;
      d_opcode_q  <= d_opcode_d;
      d_denied_q  <= d_denied_d;
      d_corrupt_q <= d_corrupt_d;
      d_data_q    <= d_data_d;
      aw_done_q   <= aw_done_d;
      w_done_q    <= w_done_d;
    end
  end

  // Gated by reset so nothing is offered or accepted while reset is held.
  assign auto_in_a_ready = (state_q == StIdle) && !reset;

  assign auto_in_d_valid        = (state_q == StResp);
  assign auto_in_d_bits_opcode  = d_opcode_q;
  assign auto_in_d_bits_size    = size_q;
  assign auto_in_d_bits_source  = source_q;
  assign auto_in_d_bits_denied  = d_denied_q;
  assign auto_in_d_bits_data    = d_data_q;
  assign auto_in_d_bits_corrupt = d_corrupt_q;

  assign auto_out_aw_valid     = (state_q == StWr) && !aw_done_q;
  assign auto_out_aw_bits_id   = 4'(AXI_ID);
  assign auto_out_aw_bits_addr = addr_q;
  assign auto_out_aw_bits_len  = 8'd0;
  assign auto_out_aw_bits_size = size_q;

  assign auto_out_w_valid     = (state_q == StWr) && !w_done_q;
  assign auto_out_w_bits_data = wdata_q;
  assign auto_out_w_bits_strb = mask_q;
  assign auto_out_w_bits_last = 1'b1;

  assign auto_out_b_ready = (state_q == StB);

  assign auto_out_ar_valid     = (state_q == StAr);
  assign auto_out_ar_bits_id   = 4'(AXI_ID);
  assign auto_out_ar_bits_addr = addr_q;
  assign auto_out_ar_bits_len  = 8'd0;
  assign auto_out_ar_bits_size = size_q;

  assign auto_out_r_ready = (state_q == StR);

endmodule

// File: tb/tb_tl_to_axi4.sv
// Self-checking bench for tl_to_axi4: directed cases followed by randomized
// transactions. The bench plays the AXI slave with per-channel ready/valid
// delays and predicts every D response from the TL/AXI transaction rules.
module tb_tl_to_axi4;

  localparam int unsigned AxiId = 0;

  logic         clock = 1'b0;
  logic         reset;
  logic         auto_in_a_ready;
  logic         auto_in_a_valid;
  logic [2:0]   auto_in_a_bits_opcode;
  logic [2:0]   auto_in_a_bits_size;
  logic [8:0]   auto_in_a_bits_source;
  logic [35:0]  auto_in_a_bits_address;
  logic [31:0]  auto_in_a_bits_mask;
  logic [255:0] auto_in_a_bits_data;
  logic         auto_in_d_ready;
  logic         auto_in_d_valid;
  logic [2:0]   auto_in_d_bits_opcode;
  logic [2:0]   auto_in_d_bits_size;
  logic [8:0]   auto_in_d_bits_source;
  logic         auto_in_d_bits_denied;
  logic [255:0] auto_in_d_bits_data;
  logic         auto_in_d_bits_corrupt;
  logic         auto_out_aw_ready;
  logic         auto_out_aw_valid;
  logic [3:0]   auto_out_aw_bits_id;
  logic [35:0]  auto_out_aw_bits_addr;
  logic [7:0]   auto_out_aw_bits_len;
  logic [2:0]   auto_out_aw_bits_size;
  logic         auto_out_w_ready;
  logic         auto_out_w_valid;
  logic [255:0] auto_out_w_bits_data;
  logic [31:0]  auto_out_w_bits_strb;
  logic         auto_out_w_bits_last;
  logic         auto_out_b_ready;
  logic         auto_out_b_valid;
  logic [3:0]   auto_out_b_bits_id;
  logic [1:0]   auto_out_b_bits_resp;
  logic         auto_out_ar_ready;
  logic         auto_out_ar_valid;
  logic [3:0]   auto_out_ar_bits_id;
  logic [35:0]  auto_out_ar_bits_addr;
  logic [7:0]   auto_out_ar_bits_len;
  logic [2:0]   auto_out_ar_bits_size;
  logic         auto_out_r_ready;
  logic         auto_out_r_valid;
  logic [3:0]   auto_out_r_bits_id;
  logic [255:0] auto_out_r_bits_data;
  logic [1:0]   auto_out_r_bits_resp;
  logic         auto_out_r_bits_last;

  tl_to_axi4 #(.AXI_ID(AxiId), .MAX_SIZE(5)) dut (
    .clock                  (clock),
    .reset                  (reset),
    .auto_in_a_ready        (auto_in_a_ready),
    .auto_in_a_valid        (auto_in_a_valid),
    .auto_in_a_bits_opcode  (auto_in_a_bits_opcode),
    .auto_in_a_bits_size    (auto_in_a_bits_size),
    .auto_in_a_bits_source  (auto_in_a_bits_source),
    .auto_in_a_bits_address (auto_in_a_bits_address),
    .auto_in_a_bits_mask    (auto_in_a_bits_mask),
    .auto_in_a_bits_data    (auto_in_a_bits_data),
    .auto_in_d_ready        (auto_in_d_ready),
    .auto_in_d_valid        (auto_in_d_valid),
    .auto_in_d_bits_opcode  (auto_in_d_bits_opcode),
    .auto_in_d_bits_size    (auto_in_d_bits_size),
    .auto_in_d_bits_source  (auto_in_d_bits_source),
    .auto_in_d_bits_denied  (auto_in_d_bits_denied),
    .auto_in_d_bits_data    (auto_in_d_bits_data),
    .auto_in_d_bits_corrupt (auto_in_d_bits_corrupt),
    .auto_out_aw_ready      (auto_out_aw_ready),
    .auto_out_aw_valid      (auto_out_aw_valid),
    .auto_out_aw_bits_id    (auto_out_aw_bits_id),
    .auto_out_aw_bits_addr  (auto_out_aw_bits_addr),
    .auto_out_aw_bits_len   (auto_out_aw_bits_len),
    .auto_out_aw_bits_size  (auto_out_aw_bits_size),
    .auto_out_w_ready       (auto_out_w_ready),
    .auto_out_w_valid       (auto_out_w_valid),
    .auto_out_w_bits_data   (auto_out_w_bits_data),
    .auto_out_w_bits_strb   (auto_out_w_bits_strb),
    .auto_out_w_bits_last   (auto_out_w_bits_last),
    .auto_out_b_ready       (auto_out_b_ready),
    .auto_out_b_valid       (auto_out_b_valid),
    .auto_out_b_bits_id     (auto_out_b_bits_id),
    .auto_out_b_bits_resp   (auto_out_b_bits_resp),
    .auto_out_ar_ready      (auto_out_ar_ready),
    .auto_out_ar_valid      (auto_out_ar_valid),
    .auto_out_ar_bits_id    (auto_out_ar_bits_id),
    .auto_out_ar_bits_addr  (auto_out_ar_bits_addr),
    .auto_out_ar_bits_len   (auto_out_ar_bits_len),
    .auto_out_ar_bits_size  (auto_out_ar_bits_size),
    .auto_out_r_ready       (auto_out_r_ready),
    .auto_out_r_valid       (auto_out_r_valid),
    .auto_out_r_bits_id     (auto_out_r_bits_id),
    .auto_out_r_bits_data   (auto_out_r_bits_data),
    .auto_out_r_bits_resp   (auto_out_r_bits_resp),
    .auto_out_r_bits_last   (auto_out_r_bits_last)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are sampled there too.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_slave();
    auto_out_ar_ready = 1'b0;
    auto_out_aw_ready = 1'b0;
    auto_out_w_ready  = 1'b0;
    auto_out_r_valid  = 1'b0;
    auto_out_b_valid  = 1'b0;
    auto_in_d_ready   = 1'b0;
  endtask

  task automatic wait_a_ready();
    int guard = 0;
    while (!auto_in_a_ready && guard < 50) begin
      step();
      guard++;
    end
    if (guard >= 50) check_eq("a_ready_timeout", 1'b0, 1'b1);
  endtask

  // One TL transaction with the bench acting as AXI slave. Delays count cycles
  // a ready (or valid) is held low after the partner side becomes eligible.
  task automatic run_txn(input logic [2:0] op, input logic [2:0] sz, input logic [8:0] src,
                         input logic [35:0] addr, input logic [31:0] mask,
                         input logic [255:0] wdata, input logic [255:0] rdata,
                         input logic [1:0] resp, input int ard, input int rd,
                         input int awd, input int wd, input int bd, input int dd);
    bit is_get, legal, ar_hs, aw_hs, w_hs, r_hs, b_hs, d_hs, unstable;
    int cyc, lat, ar_cnt, aw_cnt, w_cnt, r_wait, b_wait, d_cnt;
    logic [2:0]   c_op, c_size;
    logic [8:0]   c_src;
    logic         c_den, c_cor;
    logic [255:0] c_data;
    logic [255:0] exp_data;

    // Reference model of the response, straight from the TL/AXI rules.
    is_get   = (op == 3'd4);
    legal    = (is_get || op == 3'd0 || op == 3'd1) && (sz <= 3'd5);
    exp_data = (is_get && legal) ? rdata : '0;

    {ar_hs, aw_hs, w_hs, r_hs, b_hs, d_hs, unstable} = '0;
    {ar_cnt, aw_cnt, w_cnt, r_wait, b_wait, d_cnt} = '0;
    lat = -1;
    {c_op, c_size, c_src, c_den, c_cor, c_data} = '0;

    wait_a_ready();
    auto_in_a_valid        = 1'b1;
    auto_in_a_bits_opcode  = op;
    auto_in_a_bits_size    = sz;
    auto_in_a_bits_source  = src;
    auto_in_a_bits_address = addr;
    auto_in_a_bits_mask    = mask;
    auto_in_a_bits_data    = wdata;
    step();
    auto_in_a_valid = 1'b0;
    cyc = 1;

    while (!d_hs && cyc < 200) begin
      // R and B eligibility uses handshakes from earlier cycles.
      if (ar_hs && !r_hs) begin
        r_wait++;
        auto_out_r_valid = (r_wait > rd);
      end else auto_out_r_valid = 1'b0;
      auto_out_r_bits_data = rdata;
      auto_out_r_bits_resp = resp;
      if (auto_out_r_valid && auto_out_r_ready) r_hs = 1'b1;

      if (aw_hs && w_hs && !b_hs) begin
        b_wait++;
        auto_out_b_valid = (b_wait > bd);
      end else auto_out_b_valid = 1'b0;
      auto_out_b_bits_resp = resp;
      if (auto_out_b_valid && auto_out_b_ready) b_hs = 1'b1;

      auto_out_ar_ready = 1'b0;
      if (auto_out_ar_valid) begin
        ar_cnt++;
        if (ar_cnt == 1) begin
          check_eq("ar_addr", auto_out_ar_bits_addr, addr);
          check_eq("ar_size", auto_out_ar_bits_size, sz);
          check_eq("ar_len", auto_out_ar_bits_len, 8'd0);
          check_eq("ar_id", auto_out_ar_bits_id, 4'(AxiId));
        end
        auto_out_ar_ready = (ar_cnt > ard);
        if (auto_out_ar_ready) ar_hs = 1'b1;
      end

      auto_out_aw_ready = 1'b0;
      if (auto_out_aw_valid) begin
        aw_cnt++;
        if (aw_cnt == 1) begin
          check_eq("aw_addr", auto_out_aw_bits_addr, addr);
          check_eq("aw_size", auto_out_aw_bits_size, sz);
          check_eq("aw_len", auto_out_aw_bits_len, 8'd0);
          check_eq("aw_id", auto_out_aw_bits_id, 4'(AxiId));
        end
        auto_out_aw_ready = (aw_cnt > awd);
        if (auto_out_aw_ready) aw_hs = 1'b1;
      end

      auto_out_w_ready = 1'b0;
      if (auto_out_w_valid) begin
        w_cnt++;
        if (w_cnt == 1) begin
          check_eq("w_data", auto_out_w_bits_data, wdata);
          check_eq("w_strb", auto_out_w_bits_strb, mask);
          check_eq("w_last", auto_out_w_bits_last, 1'b1);
        end
        auto_out_w_ready = (w_cnt > wd);
        if (auto_out_w_ready) w_hs = 1'b1;
      end

      auto_in_d_ready = 1'b0;
      if (auto_in_d_valid) begin
        if (d_cnt == 0) begin
          lat    = cyc;
          c_op   = auto_in_d_bits_opcode;
          c_size = auto_in_d_bits_size;
          c_src  = auto_in_d_bits_source;
          c_den  = auto_in_d_bits_denied;
          c_cor  = auto_in_d_bits_corrupt;
          c_data = auto_in_d_bits_data;
        end else if (c_op !== auto_in_d_bits_opcode || c_size !== auto_in_d_bits_size ||
                     c_src !== auto_in_d_bits_source || c_den !== auto_in_d_bits_denied ||
                     c_cor !== auto_in_d_bits_corrupt || c_data !== auto_in_d_bits_data) begin
          unstable = 1'b1;
        end
        if (auto_in_a_ready) unstable = 1'b1;
        d_cnt++;
        auto_in_d_ready = (d_cnt > dd);
        if (auto_in_d_ready) d_hs = 1'b1;
      end

      step();
      cyc++;
    end
    clear_slave();

    if (!d_hs) begin
      check_eq("d_timeout", 1'b0, 1'b1);
      reset = 1'b1;
      step();
      reset = 1'b0;
      #1;
    end else begin
      check_eq("a_ready_after_d", auto_in_a_ready, 1'b1);
      check_eq("d_opcode", c_op, is_get ? 3'd1 : 3'd0);
      check_eq("d_size", c_size, sz);
      check_eq("d_source", c_src, src);
      check_eq("d_denied", c_den, !legal || resp != 2'd0);
      check_eq("d_corrupt", c_cor, is_get && (!legal || resp != 2'd0));
      check_eq("d_data", c_data, exp_data);
      check_eq("d_stable", unstable, 1'b0);
      check_eq("ar_valid_cycles", ar_cnt, (legal && is_get) ? ard + 1 : 0);
      check_eq("aw_valid_cycles", aw_cnt, (legal && !is_get) ? awd + 1 : 0);
      check_eq("w_valid_cycles", w_cnt, (legal && !is_get) ? wd + 1 : 0);
      if (legal && ard == 0 && rd == 0 && awd == 0 && wd == 0 && bd == 0)
        check_eq("min_latency", lat, 3);
    end
  endtask

  function automatic logic [255:0] rand256();
    logic [255:0] v;
    for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  initial begin
    logic [255:0] pat;
    logic [63:0]  a64;
    logic [2:0]   op, sz;
    logic [1:0]   rs;
    int           guard;
    bit           d_seen;

    reset                  = 1'b1;
    auto_in_a_valid        = 1'b0;
    auto_in_a_bits_opcode  = '0;
    auto_in_a_bits_size    = '0;
    auto_in_a_bits_source  = '0;
    auto_in_a_bits_address = '0;
    auto_in_a_bits_mask    = '0;
    auto_in_a_bits_data    = '0;
    auto_out_b_bits_id     = '0;
    auto_out_b_bits_resp   = '0;
    auto_out_r_bits_id     = '0;
    auto_out_r_bits_data   = '0;
    auto_out_r_bits_resp   = '0;
    auto_out_r_bits_last   = 1'b1;
    clear_slave();
    repeat (3) step();
    reset = 1'b0;
    #1;

    // Reset state.
    check_eq("rst_a_ready", auto_in_a_ready, 1'b1);
    check_eq("rst_d_valid", auto_in_d_valid, 1'b0);
    check_eq("rst_axi_valids",
             {auto_out_ar_valid, auto_out_aw_valid, auto_out_w_valid}, 3'b000);
    check_eq("rst_axi_readies", {auto_out_r_ready, auto_out_b_ready}, 2'b00);
    check_eq("rst_d_fields", {auto_in_d_bits_opcode, auto_in_d_bits_size,
             auto_in_d_bits_source, auto_in_d_bits_denied, auto_in_d_bits_corrupt}, '0);
    check_eq("rst_d_data", auto_in_d_bits_data, '0);

    pat = {8{32'hDEADBEEF}};
    // Basic Get at minimum latency.
    run_txn(3'd4, 3'd5, 9'h1A5, 36'h0_8000_0040, 32'h0, '0, pat, 2'd0, 0, 0, 0, 0, 0, 0);
    // PutPartial with AW stalled 4 cycles while W goes straight through.
    pat = rand256();
    run_txn(3'd1, 3'd5, 9'h033, 36'h1_2345_6780, 32'h0000_00FF, pat, '0, 2'd0,
            0, 0, 4, 0, 0, 0);
    // W stalled instead of AW.
    run_txn(3'd0, 3'd3, 9'h044, 36'h0_0000_1008, 32'hFFFF_FFFF, rand256(), '0, 2'd0,
            0, 0, 0, 3, 1, 0);
    // Error responses.
    run_txn(3'd4, 3'd2, 9'h055, 36'h0_0000_0100, 32'h0, '0, rand256(), 2'd2, 0, 0, 0, 0, 0, 0);
    run_txn(3'd0, 3'd4, 9'h066, 36'h0_0000_0200, 32'hFFFF, rand256(), '0, 2'd3, 0, 0, 0, 0, 0, 0);
    // Locally denied: oversize Get and an Arithmetic opcode.
    run_txn(3'd4, 3'd6, 9'h077, 36'h0_0000_0300, 32'h0, '0, rand256(), 2'd0, 0, 0, 0, 0, 0, 0);
    run_txn(3'd2, 3'd2, 9'h088, 36'h0_0000_0400, 32'hF, rand256(), '0, 2'd0, 0, 0, 0, 0, 0, 0);
    // D backpressure.
    run_txn(3'd4, 3'd5, 9'h099, 36'h0_0000_0500, 32'h0, '0, rand256(), 2'd0, 1, 2, 0, 0, 0, 6);

    // Reset while in R waiting for read data.
    wait_a_ready();
    auto_in_a_valid        = 1'b1;
    auto_in_a_bits_opcode  = 3'd4;
    auto_in_a_bits_size    = 3'd5;
    auto_in_a_bits_source  = 9'h0AA;
    auto_in_a_bits_address = 36'h0_0000_0600;
    step();
    auto_in_a_valid   = 1'b0;
    auto_out_ar_ready = 1'b1;
    guard = 0;
    while (!auto_out_r_ready && guard < 20) begin
      step();
      guard++;
    end
    check_eq("reach_r_state", auto_out_r_ready, 1'b1);
    auto_out_ar_ready = 1'b0;
    reset = 1'b1;
    step();
    reset = 1'b0;
    #1;
    check_eq("midrst_a_ready", auto_in_a_ready, 1'b1);
    check_eq("midrst_valids", {auto_out_ar_valid, auto_out_aw_valid, auto_out_w_valid,
             auto_in_d_valid, auto_out_r_ready, auto_out_b_ready}, 6'b0);
    d_seen = 1'b0;
    repeat (5) begin
      step();
      if (auto_in_d_valid) d_seen = 1'b1;
    end
    check_eq("midrst_no_d", d_seen, 1'b0);
    run_txn(3'd4, 3'd5, 9'h0BB, 36'h0_0000_0700, 32'h0, '0, rand256(), 2'd0, 0, 0, 0, 0, 0, 0);

    // Randomized transactions.
    for (int t = 0; t < 40; t++) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3: op = 3'd4;
        4, 5:       op = 3'd0;
        6, 7:       op = 3'd1;
        default:    op = 3'($urandom_range(2, 7));
      endcase
      sz  = ($urandom_range(0, 9) < 8) ? 3'($urandom_range(0, 5)) : 3'($urandom_range(6, 7));
      rs  = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
      a64 = {$urandom, $urandom};
      run_txn(op, sz, 9'($urandom), a64[35:0], $urandom, rand256(), rand256(), rs,
              $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
              $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/tl_to_axi4.md
Name: tl_to_axi4

Overview:
- Bridge from a TileLink-UL manager port to an AXI4 master port: the reverse direction of the AXI4-to-TL bridge.
- Accepts single-beat Get / PutFullData / PutPartialData on TL channel A and issues the matching single-beat AXI4 read or write.
- Returns AccessAckData / AccessAck on TL channel D.
- Sits between the L3/DMA test fabric and AXI memory/peripheral models; one transaction in flight at a time.

Parameters:
- AXI_ID, 0, constant AXI ID driven on AR/AW; R/B ids are not checked.
- MAX_SIZE, 5, largest TL size (log2 bytes) accepted; 5 = 32 bytes = one 256-bit beat.

Ports:
- clock  in  1  clock
- reset  in  1  synchronous active-high reset
- auto_in_a_ready  out  1  TL A ready
- auto_in_a_valid  in  1  TL A valid
- auto_in_a_bits_opcode  in  3  0=PutFull, 1=PutPartial, 4=Get
- auto_in_a_bits_size  in  3  log2 bytes
- auto_in_a_bits_source  in  9  requester source id
- auto_in_a_bits_address  in  36  byte address
- auto_in_a_bits_mask  in  32  byte mask
- auto_in_a_bits_data  in  256  write data
- auto_in_d_ready  in  1  TL D ready
- auto_in_d_valid  out  1  TL D valid
- auto_in_d_bits_opcode  out  3  0=AccessAck, 1=AccessAckData
- auto_in_d_bits_size  out  3  echoed a_size
- auto_in_d_bits_source  out  9  echoed a_source
- auto_in_d_bits_denied  out  1  error response
- auto_in_d_bits_data  out  256  read data
- auto_in_d_bits_corrupt  out  1  data invalid
- auto_out_aw_ready  in  1  AXI AW ready
- auto_out_aw_valid  out  1  AXI AW valid
- auto_out_aw_bits_id  out  4  = AXI_ID
- auto_out_aw_bits_addr  out  36  = latched a_address
- auto_out_aw_bits_len  out  8  always 0
- auto_out_aw_bits_size  out  3  = latched a_size
- auto_out_w_ready  in  1  AXI W ready
- auto_out_w_valid  out  1  AXI W valid
- auto_out_w_bits_data  out  256  latched a_data
- auto_out_w_bits_strb  out  32  latched a_mask
- auto_out_w_bits_last  out  1  always 1
- auto_out_b_ready  out  1  AXI B ready
- auto_out_b_valid  in  1  AXI B valid
- auto_out_b_bits_id  in  4  ignored
- auto_out_b_bits_resp  in  2  write response
- auto_out_ar_ready  in  1  AXI AR ready
- auto_out_ar_valid  out  1  AXI AR valid
- auto_out_ar_bits_id  out  4  = AXI_ID
- auto_out_ar_bits_addr  out  36  = latched a_address
- auto_out_ar_bits_len  out  8  always 0
- auto_out_ar_bits_size  out  3  = latched a_size
- auto_out_r_ready  out  1  AXI R ready
- auto_out_r_valid  in  1  AXI R valid
- auto_out_r_bits_id  in  4  ignored
- auto_out_r_bits_data  in  256  read data
- auto_out_r_bits_resp  in  2  read response
- auto_out_r_bits_last  in  1  ignored; len is 0

Behaviour:
- Clock and reset: single clock `clock`; `reset` is synchronous, active-high.
- Reset: state=IDLE, all valid/ready outputs 0, all D fields and latched registers 0.
- States and outputs:
  - IDLE: a_ready=1. On a_valid, latch opcode/size/source/address/mask/data.
    - Get with size<=MAX_SIZE -> AR.
    - Put (0/1) with size<=MAX_SIZE -> WR.
    - Any other opcode, or size>MAX_SIZE -> RESP with denied=1 and no AXI traffic. D opcode is 1 for Get, 0 otherwise; corrupt=1 for Get.
  - AR: ar_valid=1 until ar_ready, then go to R. Earliest ar_valid is the cycle after A accept.
  - R: r_ready=1. On r_valid, latch data. denied=corrupt=(resp!=0). d_opcode=1. Go to RESP.
  - WR: aw_valid and w_valid both assert on entry and drop independently on their own handshakes (per-channel done flags). The two handshakes may occur in the same cycle or in either order. Go to B when both are done.
  - B: b_ready=1. On b_valid, denied=(resp!=0), corrupt=0, d_opcode=0. Go to RESP.
  - RESP: d_valid=1 with fields held stable until d_ready, then go to IDLE. a_ready is 0 throughout RESP, so there is no A/D overlap. The next A is accepted at the earliest the cycle after the D handshake.
- Ready/valid in non-owning states: r_ready/b_ready are 0 outside R/B. Stray r_valid/b_valid in other states are not consumed.
- D data: 0 for AccessAck and for locally denied responses.
- Minimum latency:
  - Get: A accept -> D valid = 3 cycles, with ar_ready and r_valid both at the first opportunity.
  - Put: A accept -> D valid = 3 cycles.
- Mid-transaction reset: returns to IDLE immediately, drops all valids, and discards the in-flight transaction. No D response is issued for it.

Test Plan:
- Get addr 0x0_8000_0040, size 5, source 0x1A5; AXI R data 0xDEAD..BEEF, resp 0 -> AR addr 0x0_8000_0040, len 0, size 5, id AXI_ID; D opcode 1, source 0x1A5, data 0xDEAD..BEEF, denied 0, corrupt 0, 3 cycles after A.
- PutPartial mask 0x0000_00FF, data pattern; aw_ready held 0 for 4 cycles while W accepts immediately -> w_valid drops after 1 cycle, aw_valid held 5 cycles; B resp 0 -> D opcode 0, denied 0.
- Get with R resp 2 (SLVERR) -> D opcode 1, denied 1, corrupt 1. PutFull with B resp 3 -> D opcode 0, denied 1, corrupt 0.
- Get size 6, and opcode 2 (Arithmetic) -> no AR/AW/W valid ever asserted; D denied 1 (opcode 1/corrupt 1 for Get, opcode 0 for opcode 2).
- D backpressure: d_ready low 6 cycles -> d fields stable, a_ready 0; a_valid held high is accepted only the cycle after the D handshake.
- Reset asserted while in R awaiting r_valid -> next cycle all valids 0, a_ready 1; a following Get completes normally.
